dense_row_feeder: RTL and testbench

// - Input-side producer for the dense layer: captures one H x W x DEPTH feature map, streamed one pixel per beat from the conv/pool stage.
// - Replays that map to the dense layer as W-pixel rows, once per bias/output neuron.
// - Each row is held stable for the dense layer's row-processing time.
// - Owns the valid_i/data_i side of the dense layer; the dense layer has no backpressure, so this block owns all timing.

---
 rtl/dense_row_feeder.sv | 232 +++++++++++++++++++++++
 tb/tb_dense_row_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dense_row_feeder.sv
// rtl/dense_row_feeder.sv - captures one HxWxDEPTH feature map and replays it row by row to the dense layer
//
// Purpose: accepts one pixel per beat (raster order, x fastest) into a frame
// buffer, then replays the buffer as W-pixel rows, BIAS times over, holding
// each row for ROW_CYCLES cycles. The dense layer has no backpressure, so
// this block owns all output timing.
//
// Ports:
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   valid_i        pixel beat valid
//   data_i         one pixel; channel c at [c*DW +: DW]
//   ready_o        block accepts a pixel this cycle
//   valid_o        one-cycle pulse at the start of each row slot
//   data_o         current row; pixel x, channel c at [(c*W+x)*DW +: DW]
//   busy_o         replay in progress
//   frame_done_o   one-cycle pulse after the last row slot of a frame
//   overflow_o     sticky; a beat arrived while ready_o was low
//
// Configuration macro: DENSE_ROW_FEEDER_PINGPONG_EN
//   defined   : two frame buffers; the next frame fills during replay and
//               starts replaying back-to-back with the current one.
//   undefined : single frame buffer; ready_o is low for the whole replay.

module dense_row_feeder #(
    parameter int H          = 2,
    parameter int W          = 2,
    parameter int DEPTH      = 64,
    parameter int BIAS       = 128,
    parameter int DATA_WIDTH = 8,
    parameter int ROW_CYCLES = 128
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          valid_i,
    input  logic [DEPTH*DATA_WIDTH-1:0]   data_i,
    output logic                          ready_o,
    output logic                          valid_o,
    output logic [W*DEPTH*DATA_WIDTH-1:0] data_o,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          overflow_o
);

`ifdef DENSE_ROW_FEEDER_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    localparam int ROWW = W*DEPTH*DATA_WIDTH;
    localparam int XW   = (W > 1) ? $clog2(W) : 1;
    localparam int YW   = (H > 1) ? $clog2(H) : 1;
    localparam int SW   = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int BW   = (BIAS > 1) ? $clog2(BIAS) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(W-1);
    localparam logic [YW-1:0] Y_LAST = YW'(H-1);
    localparam logic [SW-1:0] S_LAST = SW'(ROW_CYCLES-1);
    localparam logic [BW-1:0] B_LAST = BW'(BIAS-1);

    typedef enum logic {FILL, PLAY} state_t;

    state_t          state;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [SW-1:0]   s_cnt;
    logic [YW-1:0]   h_cnt;
    logic [BW-1:0]   b_cnt;

    logic [ROWW-1:0] fbuf [NBUF][H];

    logic            fill_sel;
    logic            play_sel;

    logic            accept;
    logic            fill_last;
    logic            s_last;
    logic            h_last;
    logic            b_last;
    logic            play_last;
    logic            start;
    logic            next_row;
    logic            chain;
    logic            load;
    logic            load_sel;
    logic [YW-1:0]   load_h;
    logic [ROWW-1:0] load_row;

    assign accept    = valid_i && ready_o;
    assign fill_last = accept && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign s_last    = (s_cnt == S_LAST);
    assign h_last    = (h_cnt == Y_LAST);
    assign b_last    = (b_cnt == B_LAST);
    assign play_last = (state == PLAY) && s_last && h_last && b_last;
    assign start     = fill_last && (state == FILL);
    // Row slot boundary inside a frame (row advance or bias-pass wrap).
    assign next_row  = (state == PLAY) && s_last && !(h_last && b_last);
    assign busy_o    = (state == PLAY);

`ifdef DENSE_ROW_FEEDER_PINGPONG_EN
    logic [NBUF-1:0] full;

    // The other buffer is ready to replay if it is already full or its last
    // pixel lands on this very edge (fill always targets the non-playing buffer
    // while a replay is running).
    assign chain   = play_last && (full[~play_sel] || fill_last);
    assign ready_o = !full[fill_sel];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full     <= '0;
            fill_sel <= 1'b0;
            play_sel <= 1'b0;
        end else begin
            if (fill_last) begin
                full[fill_sel] <= 1'b1;
                fill_sel       <= ~fill_sel;
            end
            if (start) begin
                play_sel <= fill_sel;
            end
            if (play_last) begin
                full[play_sel] <= 1'b0;
                if (chain) begin
                    play_sel <= ~play_sel;
                end
            end
        end
    end
`else
    assign chain    = 1'b0;
    assign fill_sel = 1'b0;
    assign play_sel = 1'b0;
    assign ready_o  = (state == FILL);
`endif

    assign load     = start || next_row || chain;
    assign load_sel = start ? fill_sel : (chain ? ~play_sel : play_sel);
    assign load_h   = (start || chain || h_last) ? '0 : (h_cnt + YW'(1));

    // Row to present next; forwards the pixel being written this edge so a
    // row completed by the final beat is shown without an extra cycle.
    always_comb begin
        load_row = fbuf[load_sel][load_h];
        if (accept && (fill_sel == load_sel) && (y_cnt == load_h)) begin
            for (int c = 0; c < DEPTH; c++) begin
                load_row[(c*W + int'(x_cnt))*DATA_WIDTH +: DATA_WIDTH] =
                    data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Frame storage: no reset needed, contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < DEPTH; c++) begin
                fbuf[fill_sel][y_cnt][(c*W + int'(x_cnt))*DATA_WIDTH +: DATA_WIDTH] <=
                    data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= FILL;
            x_cnt        <= '0;
            y_cnt        <= '0;
            s_cnt        <= '0;
            h_cnt        <= '0;
            b_cnt        <= '0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;

            if (valid_i && !ready_o) begin
                overflow_o <= 1'b1;
            end

            if (accept) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : (y_cnt + YW'(1));
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end

            if (load) begin
                data_o  <= load_row;
                valid_o <= 1'b1;
            end

            case (state)
                FILL: begin
                    if (fill_last) begin
                        state <= PLAY;
                        s_cnt <= '0;
                        h_cnt <= '0;
                        b_cnt <= '0;
                    end
                end
                PLAY: begin
                    if (s_last) begin
                        s_cnt <= '0;
                        if (h_last) begin
                            h_cnt <= '0;
                            if (b_last) begin
                                b_cnt        <= '0;
                                frame_done_o <= 1'b1;
                                if (!chain) begin
                                    state <= FILL;
                                end
                            end else begin
                                b_cnt <= b_cnt + BW'(1);
                            end
                        end else begin
                            h_cnt <= h_cnt + YW'(1);
                        end
                    end else begin
                        s_cnt <= s_cnt + SW'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_row_feeder.sv
// tb/tb_dense_row_feeder.sv - directed self-checking bench for dense_row_feeder

module tb_dense_row_feeder;

    localparam int H          = 2;
    localparam int W          = 2;
    localparam int DEPTH      = 2;
    localparam int BIAS       = 3;
    localparam int DATA_WIDTH = 8;
    localparam int ROW_CYCLES = 4;
    localparam int PLAY_LEN   = BIAS*H*ROW_CYCLES;

    logic        clk;
    logic        rstn;
    logic        valid_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        overflow_o;

    int          checks;
    int          errors;
    logic        exp_ovf;
    logic        exp_ready_play;
    logic [15:0] pix [4];
    int          gap [4];

    dense_row_feeder #(
        .H(H), .W(W), .DEPTH(DEPTH), .BIAS(BIAS),
        .DATA_WIDTH(DATA_WIDTH), .ROW_CYCLES(ROW_CYCLES)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .valid_i(valid_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .data_o(data_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Row of two pixels: pixel x channel c at [(c*2+x)*8 +: 8].
    function automatic logic [31:0] row_of(input logic [15:0] p0, input logic [15:0] p1);
        return {p1[15:8], p0[15:8], p1[7:0], p0[7:0]};
    endfunction

    // Streams pix[0..3] with gap[k] idle cycles before each beat; returns just
    // after the edge that accepts the last beat.
    task automatic send_frame;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                valid_i = 1'b0;
                step();
            end
            valid_i = 1'b1;
            data_i  = pix[k];
            step();
        end
        valid_i = 1'b0;
        data_i  = 16'h0;
    endtask

    // Checks a full replay starting just after the last accept; optionally
    // drives one stray beat at replay cycle 'inject'.
    task automatic check_replay(input logic [31:0] r0, input logic [31:0] r1, input int inject);
        for (int i = 0; i < PLAY_LEN; i++) begin
            chk("valid_o", {63'b0, valid_o}, {63'b0, (i % ROW_CYCLES) == 0});
            chk("data_o", {32'b0, data_o}, {32'b0, ((i / ROW_CYCLES) % 2) ? r1 : r0});
            chk("busy_o", {63'b0, busy_o}, 64'd1);
            chk("ready_o", {63'b0, ready_o}, {63'b0, exp_ready_play});
            chk("frame_done_o", {63'b0, frame_done_o}, 64'd0);
            chk("overflow_o", {63'b0, overflow_o}, {63'b0, exp_ovf});
            if (i == inject) begin
                valid_i = 1'b1;
                data_i  = 16'hDEAD;
            end
            step();
            if (i == inject) begin
                valid_i = 1'b0;
                data_i  = 16'h0;
                exp_ovf = 1'b1;
            end
        end
        chk("done_pulse", {63'b0, frame_done_o}, 64'd1);
        chk("done_busy", {63'b0, busy_o}, 64'd0);
        chk("done_ready", {63'b0, ready_o}, 64'd1);
        chk("done_valid", {63'b0, valid_o}, 64'd0);
        chk("done_data_hold", {32'b0, data_o}, {32'b0, r1});
        chk("done_overflow", {63'b0, overflow_o}, {63'b0, exp_ovf});
        step();
        chk("done_one_cycle", {63'b0, frame_done_o}, 64'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_ovf = 1'b0;
`ifdef DENSE_ROW_FEEDER_PINGPONG_EN
        exp_ready_play = 1'b1;
`else
        exp_ready_play = 1'b0;
`endif
        rstn    = 1'b0;
        valid_i = 1'b0;
        data_i  = 16'h0;
        step();
        step();

        // Reset state
        chk("rst_ready", {63'b0, ready_o}, 64'd1);
        chk("rst_valid", {63'b0, valid_o}, 64'd0);
        chk("rst_data", {32'b0, data_o}, 64'd0);
        chk("rst_busy", {63'b0, busy_o}, 64'd0);
        chk("rst_done", {63'b0, frame_done_o}, 64'd0);
        chk("rst_overflow", {63'b0, overflow_o}, 64'd0);
        rstn = 1'b1;
        step();

        // Frame 1: back-to-back beats, pixel k = {k*2+1, k*2}
        pix = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        gap = '{0, 0, 0, 0};
        send_frame();
        check_replay(32'h03_01_02_00, 32'h07_05_06_04, -1);

        // Frame 2: idle gaps between beats, same data -> identical replay
        gap = '{2, 0, 3, 1};
        send_frame();
`ifdef DENSE_ROW_FEEDER_PINGPONG_EN
        check_replay(32'h03_01_02_00, 32'h07_05_06_04, -1);
`else
        // Stray beat during replay is dropped and raises sticky overflow
        check_replay(32'h03_01_02_00, 32'h07_05_06_04, 5);
        step();
        chk("overflow_sticky", {63'b0, overflow_o}, 64'd1);
`endif

        // Frame 3: reset at replay cycle 10
        pix = '{16'hA1B1, 16'hA2B2, 16'hA3B3, 16'hA4B4};
        gap = '{0, 1, 0, 0};
        send_frame();
        for (int i = 0; i < 10; i++) step();
        rstn = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, valid_o}, 64'd0);
        chk("midrst_data", {32'b0, data_o}, 64'd0);
        chk("midrst_busy", {63'b0, busy_o}, 64'd0);
        chk("midrst_ready", {63'b0, ready_o}, 64'd1);
        chk("midrst_overflow", {63'b0, overflow_o}, 64'd0);
        chk("midrst_done", {63'b0, frame_done_o}, 64'd0);
        exp_ovf = 1'b0;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("after_rst_valid", {63'b0, valid_o}, 64'd0);
            chk("after_rst_done", {63'b0, frame_done_o}, 64'd0);
        end

        // Frame 4: fresh frame after the aborted one
        pix = '{16'h1020, 16'h1121, 16'h1222, 16'h1323};
        gap = '{1, 0, 0, 2};
        send_frame();
        check_replay(row_of(16'h1020, 16'h1121), row_of(16'h1222, 16'h1323), -1);
        chk("fresh_rows_hand", {32'b0, row_of(16'h1020, 16'h1121)}, 64'h11_10_21_20);

`ifdef DENSE_ROW_FEEDER_PINGPONG_EN
        // Frame B streamed during frame A's replay continues without a gap
        pix = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        gap = '{0, 0, 0, 0};
        send_frame();
        for (int i = 0; i < PLAY_LEN; i++) begin
            chk("pp_a_valid", {63'b0, valid_o}, {63'b0, (i % ROW_CYCLES) == 0});
            if (i >= 1 && i <= 4) begin
                valid_i = 1'b1;
                data_i  = {8'h80 + 8'(2*(i-1)+1), 8'h80 + 8'(2*(i-1))};
            end else begin
                valid_i = 1'b0;
            end
            step();
        end
        valid_i = 1'b0;
        chk("pp_b_valid", {63'b0, valid_o}, 64'd1);
        chk("pp_b_data0", {32'b0, data_o}, 64'h83_81_82_80);
        chk("pp_b_busy", {63'b0, busy_o}, 64'd1);
        for (int i = 0; i < ROW_CYCLES; i++) step();
        chk("pp_b_data1", {32'b0, data_o}, 64'h87_85_86_84);
        chk("pp_b_valid1", {63'b0, valid_o}, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
